// File: rtl/flash_op_sequencer.sv
// flash_op_sequencer
//   Turns one host NAND request (page read, page program, block erase, read
//   status) into the ordered command/address/data bytes and instruction words
//   that the flash bus controller consumes. It also waits out tWB and the
//   R/B_n busy time, so the host sees one request and one completion pulse.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   op_valid/op_ready        request handshake; op_code/op_row/op_col/op_len
//                            are latched when the request is accepted
//   wd_valid/wd_data/wd_ready  host program-data byte stream (DIN only)
//   instr_wrreq/instr_data   instruction FIFO write, {16'h0, repeat, mode}
//   instr_full, iq_empty     instruction FIFO status
//   byte_wrreq/byte_data     byte FIFO write (command/address/program data)
//   byte_full                byte FIFO status
//   flash_rdy                R/B_n as seen by the controller (1 = ready)
//   op_done                  one-cycle completion pulse
//   op_err                   one-cycle busy-timeout pulse
//
// Optional feature macro: FLASH_SEQ_TIMEOUT_EN
//   Defined  : BUSY_WAIT gives up after TIMEOUT_CYCLES cycles and pulses op_err.
//   Undefined: BUSY_WAIT waits indefinitely and op_err stays 0.
module flash_op_sequencer #(
    parameter int          WB_CYCLES      = 8,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd800000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_code,
    input  logic [23:0] op_row,
    input  logic [15:0] op_col,
    input  logic [11:0] op_len,
    input  logic        wd_valid,
    input  logic [7:0]  wd_data,
    output logic        wd_ready,
    output logic        instr_wrreq,
    output logic [31:0] instr_data,
    input  logic        instr_full,
    input  logic        iq_empty,
    output logic        byte_wrreq,
    output logic [7:0]  byte_data,
    input  logic        byte_full,
    input  logic        flash_rdy,
    output logic        op_done,
    output logic        op_err
);

    typedef enum logic [3:0] {
        IDLE, CMD1, ADDR, DIN, CMD2, DRAIN, WB_WAIT, BUSY_WAIT, DOUT, DONE
    } state_t;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_PROG  = 2'd1;
    localparam logic [1:0] OP_ERASE = 2'd2;
    localparam logic [1:0] OP_STAT  = 2'd3;

    localparam logic [3:0] M_CMD  = 4'd2;
    localparam logic [3:0] M_ADDR = 4'd3;
    localparam logic [3:0] M_DIN  = 4'd4;
    localparam logic [3:0] M_DOUT = 4'd5;

    state_t      state, state_nx;
    logic [1:0]  code;
    logic [23:0] row;
    logic [15:0] col;
    logic [11:0] len;
    // cnt is the byte index inside ADDR/DIN and the cycle count in WB_WAIT
    logic [11:0] cnt, cnt_nx;
    // iw: the phase's bytes are all queued, now writing its instruction word
    logic        iw, iw_nx;
    logic [7:0]  cmd1_byte, cmd2_byte, addr_byte;
    logic [2:0]  addr_idx;
    logic [11:0] addr_last;

    function automatic logic [31:0] iword(input logic [3:0] mode, input logic [11:0] rep);
        return {16'h0000, rep, mode};
    endfunction

`ifdef FLASH_SEQ_TIMEOUT_EN
    logic [19:0] tmo;
    always_ff @(posedge clk) begin
        if (rst || state != BUSY_WAIT) tmo <= 20'd0;
        else                           tmo <= tmo + 20'd1;
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 12'd0;
            iw    <= 1'b0;
            code  <= 2'd0;
            row   <= 24'd0;
            col   <= 16'd0;
            len   <= 12'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            iw    <= iw_nx;
            if (state == IDLE && op_valid) begin
                code <= op_code;
                row  <= op_row;
                col  <= op_col;
                len  <= op_len;
            end
        end
    end

    always_comb begin
        cmd1_byte = 8'h70;
        cmd2_byte = 8'h00;
        case (code)
            OP_READ:  begin cmd1_byte = 8'h00; cmd2_byte = 8'h30; end
            OP_PROG:  begin cmd1_byte = 8'h80; cmd2_byte = 8'h10; end
            OP_ERASE: begin cmd1_byte = 8'h60; cmd2_byte = 8'hD0; end
            default:  ;
        endcase
        // erase skips the two column bytes, so it starts at row[7:0]
        addr_idx  = (code == OP_ERASE) ? cnt[2:0] + 3'd2 : cnt[2:0];
        addr_last = (code == OP_ERASE) ? 12'd2 : 12'd4;
        case (addr_idx)
            3'd0:    addr_byte = col[7:0];
            3'd1:    addr_byte = col[15:8];
            3'd2:    addr_byte = row[7:0];
            3'd3:    addr_byte = row[15:8];
            default: addr_byte = row[23:16];
        endcase
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        iw_nx       = iw;
        op_ready    = 1'b0;
        wd_ready    = 1'b0;
        instr_wrreq = 1'b0;
        instr_data  = 32'h0;
        byte_wrreq  = 1'b0;
        byte_data   = 8'hAA;
        op_done     = 1'b0;
        op_err      = 1'b0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                cnt_nx   = 12'd0;
                iw_nx    = 1'b0;
                if (op_valid) state_nx = CMD1;
            end
            CMD1, CMD2: begin
                if (!iw) begin
                    byte_data = (state == CMD1) ? cmd1_byte : cmd2_byte;
                    if (!byte_full) begin
                        byte_wrreq = 1'b1;
                        iw_nx      = 1'b1;
                    end
                end else begin
                    instr_data = iword(M_CMD, 12'd0);
                    if (!instr_full) begin
                        instr_wrreq = 1'b1;
                        iw_nx       = 1'b0;
                        cnt_nx      = 12'd0;
                        if (state == CMD2)         state_nx = DRAIN;
                        else if (code == OP_STAT)  state_nx = DOUT;
                        else                       state_nx = ADDR;
                    end
                end
            end
            ADDR: begin
                if (!iw) begin
                    byte_data = addr_byte;
                    if (!byte_full) begin
                        byte_wrreq = 1'b1;
                        if (cnt == addr_last) iw_nx  = 1'b1;
                        else                  cnt_nx = cnt + 12'd1;
                    end
                end else begin
                    instr_data = iword(M_ADDR, addr_last);
                    if (!instr_full) begin
                        instr_wrreq = 1'b1;
                        iw_nx       = 1'b0;
                        cnt_nx      = 12'd0;
                        state_nx    = (code == OP_PROG) ? DIN : CMD2;
                    end
                end
            end
            DIN: begin
                if (!iw) begin
                    // host bytes pass straight through; the index stops at
                    // len instead of wrapping so len=FFF gives 4096 bytes
                    wd_ready  = !byte_full;
                    byte_data = wd_data;
                    if (wd_valid && !byte_full) begin
                        byte_wrreq = 1'b1;
                        if (cnt == len) iw_nx  = 1'b1;
                        else            cnt_nx = cnt + 12'd1;
                    end
                end else begin
                    instr_data = iword(M_DIN, len);
                    if (!instr_full) begin
                        instr_wrreq = 1'b1;
                        iw_nx       = 1'b0;
                        state_nx    = CMD2;
                    end
                end
            end
            DRAIN: begin
                cnt_nx = 12'd0;
                if (iq_empty) state_nx = WB_WAIT;
            end
            WB_WAIT: begin
                if (cnt == 12'(WB_CYCLES - 1)) state_nx = BUSY_WAIT;
                else                           cnt_nx   = cnt + 12'd1;
            end
            BUSY_WAIT: begin
                if (flash_rdy) state_nx = (code == OP_READ) ? DOUT : DONE;
`ifdef FLASH_SEQ_TIMEOUT_EN
                else if (tmo == TIMEOUT_CYCLES - 20'd1) begin
                    op_err   = 1'b1;
                    state_nx = IDLE;
                end
`endif
            end
            DOUT: begin
                instr_data = iword(M_DOUT, (code == OP_READ) ? len : 12'd0);
                if (!instr_full) begin
                    instr_wrreq = 1'b1;
                    state_nx    = DONE;
                end
            end
            DONE: begin
                op_done  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // reset silences every output in the same cycle it is asserted
        if (rst) begin
            op_ready    = 1'b0;
            wd_ready    = 1'b0;
            instr_wrreq = 1'b0;
            instr_data  = 32'h0;
            byte_wrreq  = 1'b0;
            byte_data   = 8'hAA;
            op_done     = 1'b0;
            op_err      = 1'b0;
        end
    end

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Randomized self-checking bench for flash_op_sequencer. A reference model
// builds the expected ordered stream of byte/instruction writes per request;
// a per-cycle monitor compares every write strobe, wd_ready, and the
// completion timing against it.
module tb_flash_op_sequencer;
    localparam int WB = 8;
    localparam int T_NONE = 0, T_DIN = 1, T_CMD1 = 2, T_CMD2 = 3, T_DOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_ready;
    logic [1:0]  op_code;
    logic [23:0] op_row;
    logic [15:0] op_col;
    logic [11:0] op_len;
    logic        wd_valid, wd_ready;
    logic [7:0]  wd_data;
    logic        instr_wrreq, instr_full, iq_empty;
    logic [31:0] instr_data;
    logic        byte_wrreq, byte_full;
    logic [7:0]  byte_data;
    logic        flash_rdy, op_done, op_err;

    always #5 clk = ~clk;

    flash_op_sequencer #(.WB_CYCLES(WB), .TIMEOUT_CYCLES(20'd100)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_row(op_row), .op_col(op_col), .op_len(op_len),
        .wd_valid(wd_valid), .wd_data(wd_data), .wd_ready(wd_ready),
        .instr_wrreq(instr_wrreq), .instr_data(instr_data), .instr_full(instr_full),
        .iq_empty(iq_empty), .byte_wrreq(byte_wrreq), .byte_data(byte_data),
        .byte_full(byte_full), .flash_rdy(flash_rdy), .op_done(op_done), .op_err(op_err)
    );

    typedef struct {
        bit          instr;
        logic [31:0] val;
        int          tag;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] wd_mem[4096];
    int n_vec = 0, n_bad = 0;
    int cyc = 0;
    int wd_n = 0, wd_idx = 0;
    bit acc_f, wdx_f, instr_f, cmd1_f, cmd2_f;
    int done_cnt, err_cnt, done_cyc, err_cyc, dout_cyc;
    int iq_hold = 0, iq_rise = 0, rdy_cnt = 0, rdy_rise = 0, burst = 0;
    bit cmd2_seen, rand_full, stall;
    int rdy_delay_cur;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic pb(input logic [7:0] v, input int tag);
        ev_t e;
        e.instr = 1'b0; e.val = {24'h0, v}; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic pi(input logic [3:0] mode, input logic [11:0] rep, input int tag);
        ev_t e;
        e.instr = 1'b1; e.val = {16'h0, rep, mode}; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic build(input logic [1:0] code, input logic [23:0] row,
                         input logic [15:0] col, input logic [11:0] len);
        logic [7:0] c1, c2;
        logic [7:0] ab[$];
        case (code)
            2'd0:    begin c1 = 8'h00; c2 = 8'h30; end
            2'd1:    begin c1 = 8'h80; c2 = 8'h10; end
            2'd2:    begin c1 = 8'h60; c2 = 8'hD0; end
            default: begin c1 = 8'h70; c2 = 8'h00; end
        endcase
        pb(c1, T_NONE);
        pi(4'd2, 12'd0, T_CMD1);
        if (code != 2'd3) begin
            if (code != 2'd2) begin
                ab.push_back(col[7:0]);
                ab.push_back(col[15:8]);
            end
            ab.push_back(row[7:0]);
            ab.push_back(row[15:8]);
            ab.push_back(row[23:16]);
            foreach (ab[i]) pb(ab[i], T_NONE);
            pi(4'd3, 12'(ab.size() - 1), T_NONE);
            if (code == 2'd1) begin
                for (int i = 0; i <= int'(len); i++) pb(wd_mem[i], T_DIN);
                pi(4'd4, len, T_NONE);
            end
            pb(c2, T_NONE);
            pi(4'd2, 12'd0, T_CMD2);
        end
        if (code == 2'd0)      pi(4'd5, len, T_DOUT);
        else if (code == 2'd3) pi(4'd5, 12'd0, T_DOUT);
    endtask

    // ---------------- per-cycle monitor and environment ----------------
    task automatic sample();
        ev_t e;
        bit  din_pend;
        acc_f = 0; wdx_f = 0; instr_f = 0; cmd1_f = 0; cmd2_f = 0;
        if (rst) return;
        din_pend = (exp_q.size() > 0) && (exp_q[0].tag == T_DIN);
        chk("wd_ready", wd_ready, din_pend && !byte_full);
        acc_f = op_valid && op_ready;
        wdx_f = wd_valid && wd_ready;
        if (byte_wrreq) begin
            chk("byte_while_full", byte_full, 0);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else begin e.instr = 1'b1; e.val = '1; e.tag = -1; end
            chk("byte_kind", e.instr, 0);
            chk("byte_data", byte_data, e.val);
            if (e.tag == T_DIN) chk("din_xfer", wdx_f, 1);
        end
        if (instr_wrreq) begin
            chk("instr_while_full", instr_full, 0);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else begin e.instr = 1'b0; e.val = '1; e.tag = -1; end
            chk("instr_kind", e.instr, 1);
            chk("instr_data", instr_data, e.val);
            instr_f = 1;
            if (e.tag == T_CMD1) cmd1_f = 1;
            if (e.tag == T_CMD2) begin cmd2_f = 1; cmd2_seen = 1; end
            if (e.tag == T_DOUT) dout_cyc = cyc;
        end
        if (op_done) begin done_cnt++; done_cyc = cyc; end
        if (op_err)  begin err_cnt++;  err_cyc  = cyc; end
    endtask

    task automatic drive();
        if (acc_f) begin
            // request fields must be ignored once accepted
            op_valid = 1'b0;
            op_code  = 2'($urandom);
            op_row   = 24'($urandom);
            op_col   = 16'($urandom);
            op_len   = 12'($urandom);
        end
        if (wdx_f) wd_idx++;
        wd_valid = (wd_idx < wd_n) && ($urandom_range(0, 2) != 0);
        wd_data  = (wd_idx < wd_n) ? wd_mem[wd_idx] : 8'($urandom);
        if (instr_f) begin
            iq_empty = 1'b0;
            iq_hold  = $urandom_range(1, 4);
        end else if (!iq_empty) begin
            iq_hold--;
            if (iq_hold == 0) begin
                iq_empty = 1'b1;
                if (cmd2_seen) iq_rise = cyc;
            end
        end
        if (cmd2_f && rdy_delay_cur > 0) begin
            flash_rdy = 1'b0;
            rdy_cnt   = rdy_delay_cur;
        end else if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) begin flash_rdy = 1'b1; rdy_rise = cyc; end
        end
        if (cmd1_f && stall) burst = 10;
        if (burst > 0) begin byte_full = 1'b1; burst--; end
        else byte_full = rand_full && ($urandom_range(0, 3) == 0);
        instr_full = rand_full && ($urandom_range(0, 3) == 0);
    endtask

    task automatic tick();
        @(negedge clk); sample();
        @(posedge clk); cyc++; #1; drive();
    endtask

    task automatic start_op(input logic [1:0] code, input logic [23:0] row, input logic [15:0] col,
                            input logic [11:0] len, input int rdly, input bit rf, input bit stl);
        int n;
        exp_q.delete();
        done_cnt = 0; err_cnt = 0; cmd2_seen = 0; iq_rise = 0; rdy_rise = 0; dout_cyc = 0;
        rdy_delay_cur = rdly; rand_full = rf; stall = stl;
        wd_n = (code == 2'd1) ? int'(len) + 1 : 0;
        wd_idx = 0;
        for (int i = 0; i < wd_n; i++) wd_mem[i] = 8'($urandom);
        build(code, row, col, len);
        op_code = code; op_row = row; op_col = col; op_len = len; op_valid = 1'b1;
        n = 0;
        while (!acc_f && n < 20) begin tick(); n++; end
        chk("accept", acc_f, 1);
        op_valid = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] code, input logic [23:0] row, input logic [15:0] col,
                          input logic [11:0] len, input int rdly, input bit rf, input bit stl);
        int n, a, b;
        start_op(code, row, col, len, rdly, rf, stl);
        n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < 15000) begin tick(); n++; end
        repeat (3) tick();
        chk("done_once", done_cnt, 1);
        chk("no_err", err_cnt, 0);
        chk("exp_left", exp_q.size(), 0);
        a = iq_rise + WB + 2;
        b = rdy_rise + 1;
        if (code == 2'd1 || code == 2'd2) chk("done_latency", done_cyc, (a > b) ? a : b);
        if (code == 2'd0 && rdly > 0) chk("dout_after_rdy", dout_cyc > rdy_rise, 1);
    endtask

    initial begin
        int n;
        rst = 1'b1; op_valid = 0; op_code = 0; op_row = 0; op_col = 0; op_len = 0;
        wd_valid = 0; wd_data = 0; instr_full = 0; iq_empty = 1; byte_full = 0; flash_rdy = 1;
        rand_full = 0; stall = 0; rdy_delay_cur = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_wd_ready", wd_ready, 0);
        chk("rst_instr_wrreq", instr_wrreq, 0);
        chk("rst_byte_wrreq", byte_wrreq, 0);
        chk("rst_op_done", op_done, 0);
        chk("rst_op_err", op_err, 0);
        chk("rst_instr_data", instr_data, 0);
        chk("rst_byte_data", byte_data, 8'hAA);
        @(posedge clk); cyc++; #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", op_ready, 1);
        @(posedge clk); cyc++; #1;

        run_op(2'd2, 24'h012345, 16'h0000, 12'd0, 0, 0, 0);     // erase
        run_op(2'd0, 24'h000100, 16'h0000, 12'h7FF, 50, 0, 0);  // read page, busy 50
        run_op(2'd1, 24'hABCDEF, 16'h1234, 12'd3, 0, 0, 0);     // program 4 bytes
        run_op(2'd1, 24'h00F00F, 16'h0808, 12'd12, 0, 0, 1);    // byte_full burst in ADDR
        run_op(2'd1, 24'h135799, 16'h2468, 12'd0, 5, 1, 0);     // single data byte

        // reset in BUSY_WAIT
        start_op(2'd2, 24'h777777, 16'h0, 12'd0, 200, 0, 0);
        n = 0;
        while (!(cmd2_seen && iq_empty) && n < 200) begin tick(); n++; end
        chk("reach_drain", cmd2_seen && iq_empty, 1);
        repeat (WB + 3) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", op_ready, 0);
        chk("midrst_byte", byte_wrreq, 0);
        chk("midrst_instr", instr_wrreq, 0);
        chk("midrst_done", op_done, 0);
        @(posedge clk); cyc++; #1 rst = 1'b0;
        rdy_cnt = 0; flash_rdy = 1'b1; acc_f = 0; wdx_f = 0; instr_f = 0; cmd1_f = 0; cmd2_f = 0;
        @(negedge clk);
        chk("midrst_idle", op_ready, 1);
        @(posedge clk); cyc++; #1;
        repeat (20) tick();
        chk("midrst_no_done", done_cnt, 0);
        run_op(2'd3, 24'h0, 16'h0, 12'd0, 0, 0, 0);             // read status

        run_op(2'd1, 24'h246802, 16'h0100, 12'hFFF, 5, 1, 0);   // 4096-byte program

        for (int k = 0; k < 25; k++)
            run_op(2'($urandom_range(0, 3)), 24'($urandom), 16'($urandom),
                   12'($urandom_range(0, 20)), $urandom_range(0, 60), 1'($urandom), 0);

`ifdef FLASH_SEQ_TIMEOUT_EN
        start_op(2'd2, 24'h00ABCD, 16'h0, 12'd0, 1000, 0, 0);
        n = 0;
        while (err_cnt == 0 && done_cnt == 0 && n < 2000) begin tick(); n++; end
        chk("tmo_err", err_cnt, 1);
        chk("tmo_no_done", done_cnt, 0);
        chk("tmo_cycle", err_cyc, iq_rise + WB + 100);
        @(negedge clk);
        chk("tmo_idle", op_ready, 1);
        @(posedge clk); cyc++; #1;
        rdy_cnt = 0; flash_rdy = 1'b1;
        repeat (3) tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/flash_op_sequencer.md
Name: flash_op_sequencer

Overview:
- Translates high-level NAND operations into the ordered instruction words and command/address bytes consumed by the flash bus controller. Operations: page read, page program, block erase, read status.
- Sits between the host/core logic and the controller's two input queues: the instruction FIFO and the byte/data FIFO.
- Handles the R/B_n busy wait between command phases, so the host issues one request per operation and receives one completion pulse.

Parameters:
- WB_CYCLES, 8, clk cycles to wait after the instruction queue drains before sampling flash_rdy (covers tWB).
- TIMEOUT_CYCLES, 20'd800000, busy-wait limit (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  host request valid
- op_ready  out  1  sequencer idle; request accepted when op_valid & op_ready
- op_code  in  2  0=READ_PAGE, 1=PROGRAM_PAGE, 2=ERASE_BLOCK, 3=READ_STATUS
- op_row  in  24  row (page/block) address
- op_col  in  16  column address
- op_len  in  12  data byte count minus 1
- wd_valid  in  1  host program-data byte valid
- wd_data  in  8  host program-data byte
- wd_ready  out  1  byte accepted this cycle
- instr_wrreq  out  1  write strobe, instruction FIFO
- instr_data  out  32  {16'h0000, repeat[11:0], mode[3:0]}
- instr_full  in  1  instruction FIFO full
- iq_empty  in  1  instruction FIFO empty
- byte_wrreq  out  1  write strobe, byte FIFO
- byte_data  out  8  command/address/program byte
- byte_full  in  1  byte FIFO full
- flash_rdy  in  1  R/B_n from controller (1 = ready)
- op_done  out  1  one-cycle completion pulse
- op_err  out  1  one-cycle timeout pulse (optional feature only; otherwise tied 0)

Behaviour:
- Reset values:
  - op_ready=0 during rst, 1 on the first cycle after.
  - wd_ready, instr_wrreq, byte_wrreq, op_done and op_err are all 0.
  - instr_data=0, byte_data=8'hAA.
  - FSM is in IDLE.
- Mode codes: COMMAND=2, ADDRESS=3, DATA_INPUT=4, DATA_OUTPUT=5. The repeat field R means the mode executes R+1 times.
- On accept, latch op_code, op_row, op_col and op_len. Ignore input changes until the next IDLE.
- States: IDLE, CMD1, ADDR, DIN, CMD2, DRAIN, WB_WAIT, BUSY_WAIT, DOUT, DONE.
- Phase rule: every byte of a phase is written to the byte FIFO before that phase's instruction word is written.
- Write strobes are single-cycle and only issued when the matching full flag is 0. The FSM stalls while full is high.
- Each instruction word is written exactly once.
- Address byte order: col[7:0], col[15:8], row[7:0], row[15:8], row[23:16]. ERASE sends the 3 row bytes only.
- READ_PAGE sequence:
  - CMD1: 8'h00, instr rep 0.
  - ADDR: 5 bytes, rep 4.
  - CMD2: 8'h30, rep 0.
  - DRAIN, WB_WAIT, BUSY_WAIT.
  - DOUT: instr mode 5, rep op_len.
  - DONE.
- PROGRAM_PAGE sequence:
  - CMD1: 8'h80.
  - ADDR: 5 bytes.
  - DIN: forward op_len+1 host bytes. wd_ready = byte FIFO not full and state is DIN, so a byte transfers when wd_valid & wd_ready. Then instr mode 4, rep op_len.
  - CMD2: 8'h10.
  - DRAIN, WB_WAIT, BUSY_WAIT, DONE.
- ERASE_BLOCK sequence: CMD1 8'h60, ADDR 3 bytes with rep 2, CMD2 8'hD0, DRAIN, WB_WAIT, BUSY_WAIT, DONE.
- READ_STATUS sequence: CMD1 8'h70, then DOUT with rep 0, then DONE.
- Wait states:
  - DRAIN: wait for iq_empty=1.
  - WB_WAIT: count WB_CYCLES cycles.
  - BUSY_WAIT: leave on the first cycle flash_rdy=1.
- DONE: op_done=1 for one cycle, then IDLE. The earliest next accept is the cycle after DONE.
- Byte counter is 12 bits and counts 0..op_len inclusive. op_len=12'hFFF gives 4096 bytes with no wrap.
- op_len=0 gives exactly one data byte.
- If wd_valid and byte_full are both high, nothing transfers and wd_ready=0.
- Reset mid-operation: return to IDLE in the next cycle and drop all strobes. Downstream FIFOs are not flushed; flushing is the system's responsibility.

Optional Feature:
- FLASH_SEQ_TIMEOUT_EN defined:
  - A 20-bit counter runs in BUSY_WAIT.
  - Reaching TIMEOUT_CYCLES pulses op_err for one cycle, skips DOUT and op_done, and returns to IDLE.
- Undefined: no counter, op_err is constant 0, and BUSY_WAIT waits indefinitely.

Test Plan:
- ERASE, row=24'h012345, FIFOs never full -> byte stream 60,45,23,01,D0. Instr words 0x00000002, 0x00000023, 0x00000002. op_done exactly WB_CYCLES+1 cycles after flash_rdy rises, counted once iq_empty.
- READ_PAGE, col=16'h0000, row=24'h000100, len=12'h7FF, flash_rdy low 50 cycles -> bytes 00,00,00,00,01,00,30. Last instr 0x00007FF5 written only after flash_rdy=1. Then op_done.
- PROGRAM_PAGE, len=3, wd bytes 11,22,33,44 with wd_valid gaps -> bytes 80,<5 addr>,11,22,33,44,10. DIN instr 0x00000034 follows 44. wd_ready=0 outside DIN.
- byte_full held high for 10 cycles during ADDR -> no byte_wrreq during the stall, no duplicated or dropped byte, sequence unchanged.
- rst pulsed during BUSY_WAIT -> IDLE next cycle, op_ready=1, no op_done. A new READ_STATUS then completes with bytes 70 and instrs 0x00000002, 0x00000005.
- FLASH_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=100 and flash_rdy stuck 0 -> op_err pulse after 100 BUSY_WAIT cycles, no op_done, IDLE.
